bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that feeds the `seven_segment` display stage. It converts a 17-bit binary operand into the 21-bit sign-plus-five-digit BCD word that `seven_segment` consumes on `bcd_input`. The conversion is iterative shift-add-3 (double dabble) with a start/valid handshake. The result stays registered between conversions so the display always reads a stable value.

---
 rtl/bin2bcd_pkg.sv | 32 +++
 rtl/bcd_digit_adj.sv | 20 ++
 rtl/bin2bcd_seq.sv | 198 +++++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state type and operand helper for the bin2bcd_seq converter.
// Optional feature macro: BIN2BCD_SIGNED_EN (two's complement operand with sign bit).
package bin2bcd_pkg;

  localparam int OP_W     = 17;
  localparam int BCD_W    = 21;
  localparam int SIGN_BIT = 20;
  localparam int DIGIT_W  = 4;

  // Saturated display value: five nines, positive.
  localparam logic [BCD_W-1:0] BCD_MAX = 21'b0_1001_1001_1001_1001_1001;
  // Largest operand that fits in five decimal digits.
  localparam logic [OP_W-1:0]  DEC_MAX = 17'd99999;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Absolute value of a two's complement operand; the most negative value maps
  // onto itself, which read as unsigned is exactly its magnitude.
  function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] v);
    logic [OP_W-1:0] r;
    if (v[OP_W-1]) begin
      r = (~v) + {{(OP_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  // Add-3 correction for digits that would reach 10 or more after doubling.
  always_comb begin
    adj = digit;
    if (digit >= 4'd5) begin
      adj = digit + 4'd3;
    end else begin
      adj = digit;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) with start/valid handshake.
// One conversion takes WIDTH clock cycles; the result stays registered on
// bcd_out until the next completion or reset.
// Optional feature macro: BIN2BCD_SIGNED_EN
//   defined   : din is two's complement, bit 20 of bcd_out carries the sign.
//   undefined : din is unsigned, values above 99999 saturate with ovf=1.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 5
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    din,
  output logic                busy,
  output logic                valid,
  output logic                ovf,
  output logic [4*DIGITS:0]   bcd_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int OUT_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   mag_r;
  logic [ACC_W-1:0]   bcd_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sign_r;
  logic               sat_r;

  logic               accept_s;
  logic               done_s;
  logic [ACC_W-1:0]   adj_s;
  logic [ACC_W-1:0]   bcd_nxt_s;
  logic [WIDTH-1:0]   mag_nxt_s;
  logic [WIDTH-1:0]   mag_cap_s;
  logic               sign_cap_s;
  logic               sat_cap_s;
  logic [OUT_W-1:0]   result_s;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (bcd_r[DIGIT_W*g +: DIGIT_W]),
      .adj   (adj_s[DIGIT_W*g +: DIGIT_W])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: leave IDLE on start, return after the last iteration.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CONV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONV: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CONV;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM decodes: operand acceptance and the completion edge.
  always_comb begin
    accept_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = start;
        done_s   = 1'b0;
      end
      CONV: begin
        accept_s = 1'b0;
        if (cnt_r == CNT_ZERO) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        accept_s = 1'b0;
        done_s   = 1'b0;
      end
    endcase
  end

  // Operand capture: magnitude, sign and saturation are decided at acceptance.
  always_comb begin
    mag_cap_s  = din;
    sign_cap_s = 1'b0;
    sat_cap_s  = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    mag_cap_s  = magnitude(din);
    // A zero operand never carries a sign.
    sign_cap_s = din[WIDTH-1];
    sat_cap_s  = 1'b0;
`else
    mag_cap_s  = din;
    sign_cap_s = 1'b0;
    if (din > DEC_MAX) begin
      sat_cap_s = 1'b1;
    end else begin
      sat_cap_s = 1'b0;
    end
`endif
  end

  // One iteration: corrected digits and magnitude shift left as one word.
  always_comb begin
    bcd_nxt_s = {adj_s[ACC_W-2:0], mag_r[WIDTH-1]};
    mag_nxt_s = {mag_r[WIDTH-2:0], 1'b0};
    if (sat_r) begin
      result_s = OUT_W'(BCD_MAX);
    end else begin
      result_s = {sign_r, bcd_nxt_s};
    end
  end

  // Iteration datapath: load on accept, shift and count while converting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_r  <= {WIDTH{1'b0}};
      bcd_r  <= {ACC_W{1'b0}};
      cnt_r  <= CNT_ZERO;
      sign_r <= 1'b0;
      sat_r  <= 1'b0;
    end else if (accept_s) begin
      mag_r  <= mag_cap_s;
      bcd_r  <= {ACC_W{1'b0}};
      cnt_r  <= CNT_LOAD;
      sign_r <= sign_cap_s;
      sat_r  <= sat_cap_s;
    end else if (state_r == CONV) begin
      mag_r <= mag_nxt_s;
      bcd_r <= bcd_nxt_s;
      if (cnt_r != CNT_ZERO) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      mag_r <= mag_r;
      bcd_r <= bcd_r;
      cnt_r <= cnt_r;
    end
  end

  // Registered handshake and result; bcd_out only moves on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= {OUT_W{1'b0}};
    end else begin
      valid <= done_s;
      if (accept_s) begin
        busy <= 1'b1;
      end else if (done_s) begin
        busy <= 1'b0;
      end else begin
        busy <= busy;
      end
      if (done_s) begin
        bcd_out <= result_s;
        ovf     <= sat_r;
      end else begin
        bcd_out <= bcd_out;
        ovf     <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a cycle model built from decimal
// arithmetic is compared against the DUT on every falling edge, and directed
// conversions are pinned to hand-computed BCD words.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [16:0] din = 17'd0;
  logic        busy;
  logic        valid;
  logic        ovf;
  logic [20:0] bcd_out;

  int total = 0;
  int bad   = 0;

  bin2bcd_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .din     (din),
    .busy    (busy),
    .valid   (valid),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Expected display word from decimal arithmetic.
  function automatic logic [20:0] exp_word(input logic [16:0] d);
    int unsigned m;
    logic        neg;
    logic [20:0] w;
`ifdef BIN2BCD_SIGNED_EN
    neg = d[16];
    m   = neg ? (32'd131072 - {15'd0, d}) : {15'd0, d};
`else
    neg = 1'b0;
    m   = {15'd0, d};
    if (m > 32'd99999) return 21'h099999;
`endif
    w = 21'd0;
    for (int i = 0; i < 5; i++) begin
      w[4*i +: 4] = 4'(m % 32'd10);
      m = m / 32'd10;
    end
    w[20] = neg && (w[19:0] != 20'd0);
    return w;
  endfunction

  function automatic logic exp_ovf(input logic [16:0] d);
`ifdef BIN2BCD_SIGNED_EN
    return 1'b0;
`else
    return (d > 17'd99999);
`endif
  endfunction

  // Cycle model: a request is taken when idle, and the result lands 17 edges later.
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_ovf = 1'b0;
  logic [20:0] m_out = 21'd0;
  logic [20:0] m_pend = 21'd0;
  logic        m_pend_ovf = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_ovf   <= 1'b0;
      m_out   <= 21'd0;
      m_left  <= 0;
    end else begin
      m_valid <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_out   <= m_pend;
          m_ovf   <= m_pend_ovf;
          m_left  <= 0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_busy     <= 1'b1;
        m_left     <= 17;
        m_pend     <= exp_word(din);
        m_pend_ovf <= exp_ovf(din);
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    chk("bcd_out", {11'd0, bcd_out}, {11'd0, m_out});
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bcd_out[4*i +: 4] > 4'd9) begin
        bad++;
        $display("FAIL digit_legal: digit %0d is %0d, expected <= 9", i, bcd_out[4*i +: 4]);
      end
    end
  end

  // Drive one conversion from an idle DUT and check latency and result.
  task automatic run_conv(input string name, input logic [16:0] d,
                          input logic [20:0] want, input logic want_ovf);
    int cyc;
    logic seen;
    start = 1'b1;
    din   = d;
    @(negedge clk);
    start = 1'b0;
    din   = ~d;
    cyc   = 1;
    seen  = valid;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      seen = valid;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no valid within %0d cycles, expected one after 17", name, cyc);
    end else begin
      chk({name, "_latency"}, cyc - 1, 32'd17);
      chk({name, "_bcd"}, {11'd0, bcd_out}, {11'd0, want});
      chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, want_ovf});
    end
  endtask

  logic [16:0] ends [7] = '{17'd0, 17'd1, 17'd99999, 17'd100000,
                            17'h0FFFF, 17'h10000, 17'h1FFFF};

  initial begin
    int nv;
    logic [16:0] d;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    chk("reset_bcd", {11'd0, bcd_out}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Pin the model itself to hand-computed words.
    chk("model_12345", {11'd0, exp_word(17'd12345)}, 32'h012345);
    chk("model_0", {11'd0, exp_word(17'd0)}, 32'h0);
`ifdef BIN2BCD_SIGNED_EN
    chk("model_m1234", {11'd0, exp_word(17'h1FB2E)}, 32'h101234);
    chk("model_m65536", {11'd0, exp_word(17'h10000)}, 32'h165536);
`else
    chk("model_100000", {11'd0, exp_word(17'd100000)}, 32'h099999);
    chk("model_ovf_100000", {31'd0, exp_ovf(17'd100000)}, 32'd1);
    chk("model_ovf_99999", {31'd0, exp_ovf(17'd99999)}, 32'd0);
`endif

    // Directed conversions with literal expectations.
    run_conv("c12345", 17'd12345, 21'b0_0001_0010_0011_0100_0101, 1'b0);
`ifdef BIN2BCD_SIGNED_EN
    run_conv("cm1234", 17'h1FB2E, 21'b1_0000_0001_0010_0011_0100, 1'b0);
    run_conv("cm65536", 17'h10000, 21'b1_0110_0101_0101_0011_0110, 1'b0);
    run_conv("c0", 17'd0, 21'b0, 1'b0);
    run_conv("c65535", 17'h0FFFF, 21'b0_0110_0101_0101_0011_0101, 1'b0);
`else
    run_conv("c100000", 17'd100000, 21'b0_1001_1001_1001_1001_1001, 1'b1);
    run_conv("c99999", 17'd99999, 21'b0_1001_1001_1001_1001_1001, 1'b0);
    run_conv("c131071", 17'd131071, 21'b0_1001_1001_1001_1001_1001, 1'b1);
    run_conv("c0", 17'd0, 21'b0, 1'b0);
`endif

    // start held high with a changing operand: one result per 18 cycles.
    nv    = 0;
    start = 1'b1;
    din   = 17'(($urandom_range(0, 131071)));
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if (valid) nv++;
      din = 17'(($urandom_range(0, 131071)));
    end
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("held_valid_count", nv, 32'd3);

    // Reset in the middle of a conversion aborts it.
    start = 1'b1;
    din   = 17'd54321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_bcd", {11'd0, bcd_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nv  = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort_no_valid", nv, 32'd0);
    run_conv("c7", 17'd7, 21'b0_0000_0000_0000_0000_0111, 1'b0);

    // Range ends and a random sweep against the decimal model.
    for (int i = 0; i < 7; i++) begin
      run_conv("end", ends[i], exp_word(ends[i]), exp_ovf(ends[i]));
    end
    for (int i = 0; i < 2000; i++) begin
      d = 17'($urandom_range(0, 131071));
      run_conv("sweep", d, exp_word(d), exp_ovf(d));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
